// File: rtl/uart_rx.sv
// uart_rx: 8-bit UART receiver with oversampling bit timing and a valid/ready
// hold register.
// Optional build macro UART_RX_PARITY_EN: inserts an even-parity bit between
// the data bits and the stop bit, and makes parity_err functional.
module uart_rx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       sck,
   input  logic       rst,
   input  logic       rx,
   input  logic       ready,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       overrun,
   output logic       parity_err,
   output logic       busy
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_RECOVER
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_STOP, S_RECOVER
   } state_t;
`endif

   logic             rx_meta_q;
   logic             rxs_q;
   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       bit_q;
   logic [7:0]       shreg_q;
   logic [7:0]       data_q;
   logic             valid_q;
   logic             frame_err_q;
   logic             overrun_q;
   logic             parity_err_q;
   logic             par_bad_q;

   // Two-flop synchronizer for the asynchronous serial line; idles high.
   always_ff @(posedge sck) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rxs_q     <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rxs_q     <= rx_meta_q;
      end
   end

   // Receive FSM with bit timing, shift register and registered outputs.
   always_ff @(posedge sck) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         bit_q        <= '0;
         shreg_q      <= '0;
         data_q       <= '0;
         valid_q      <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
         parity_err_q <= 1'b0;
         par_bad_q    <= 1'b0;
      end else begin
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         // Consumer handshake; a frame landing this same cycle overrides below.
         if (valid_q && ready) valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               cnt_q <= '0;
               if (!rxs_q) state_q <= S_START;
            end
            S_START: begin
               if (cnt_q == HALF_M1) begin
                  cnt_q     <= '0;
                  bit_q     <= '0;
                  par_bad_q <= 1'b0;
                  // A start bit that is already high again mid-bit is a glitch.
                  state_q   <= rxs_q ? S_IDLE : S_DATA;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_DATA: begin
               if (cnt_q == FULL_M1) begin
                  cnt_q   <= '0;
                  shreg_q <= {rxs_q, shreg_q[7:1]};
                  bit_q   <= bit_q + 3'd1;
                  if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state_q <= S_PARITY;
`else
                     state_q <= S_STOP;
`endif
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (cnt_q == FULL_M1) begin
                  cnt_q     <= '0;
                  // Even parity: data bits plus parity bit must XOR to zero.
                  par_bad_q <= ^{shreg_q, rxs_q};
                  state_q   <= S_STOP;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
`endif
            S_STOP: begin
               if (cnt_q == FULL_M1) begin
                  cnt_q <= '0;
                  if (rxs_q) begin
                     state_q <= S_IDLE;
                     if (par_bad_q) begin
                        parity_err_q <= 1'b1;
                     end else if (valid_q && !ready) begin
                        // Held byte not consumed: drop the new one, flag it.
                        overrun_q <= 1'b1;
                     end else begin
                        data_q  <= shreg_q;
                        valid_q <= 1'b1;
                     end
                  end else begin
                     frame_err_q <= 1'b1;
                     state_q     <= S_RECOVER;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_RECOVER: begin
               // Wait out a break so it yields only one frame error.
               if (rxs_q) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
   assign busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, sck cycles per serial bit; legal range 4..1023.
REQ-002 Port sck  input  1  system clock; all logic on rising edge.
REQ-003 Port rst  input  1  reset, synchronous, active-high.
REQ-004 Port rx  input  1  serial line, idle high, asynchronous to sck.
REQ-005 Port ready  input  1  consumer accepts the held byte when high with valid.
REQ-006 Port data  output  8  received byte, LSB first on the line.
REQ-007 Port valid  output  1  data holds an unconsumed byte.
REQ-008 Port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 Port overrun  output  1  sticky: a frame completed while valid was high and ready low.
REQ-010 Port parity_err  output  1  one-cycle pulse: parity mismatch; constant 0 when parity is compiled out.
REQ-011 Port busy  output  1  high in any state other than IDLE.

Function
REQ-012 rx SHALL pass a 2-flop synchronizer; all decisions use the synchronized value rxs.
REQ-013 States SHALL be IDLE, START, DATA, PARITY (only with UART_RX_PARITY_EN), STOP, RECOVER.
REQ-014 IDLE->START SHALL occur on the first cycle rxs is low; the bit counter clears.
REQ-015 START SHALL sample rxs at count CLKS_PER_BIT/2-1 (integer division); low -> DATA with count cleared, high -> IDLE (glitch rejected, no flags).
REQ-016 DATA SHALL sample each bit when count reaches CLKS_PER_BIT-1, shift it into bit 7 of an 8-bit shift register moving right, and leave after 8 samples.
REQ-017 PARITY SHALL sample one bit at CLKS_PER_BIT-1 and check even parity over 8 data bits plus that bit.
REQ-018 STOP SHALL sample at CLKS_PER_BIT-1: high -> frame good, go to IDLE; low -> pulse frame_err, go to RECOVER.
REQ-019 RECOVER SHALL wait for rxs high, then go to IDLE; a held-low line (break) SHALL produce exactly one frame_err.
REQ-020 A good frame SHALL load data and set valid on the cycle after the stop sample.
REQ-021 A parity failure SHALL pulse parity_err on the cycle after the stop sample and SHALL NOT load data or set valid.
REQ-022 A frame_err frame SHALL NOT load data or set valid.
REQ-023 valid SHALL clear on the cycle after a sck edge with valid and ready both high; data SHALL be stable while valid is high.
REQ-024 A good frame completing while valid is high and ready low SHALL set overrun, discard the new byte, and keep the old data.
REQ-025 A good frame completing in the same cycle as a handshake SHALL load normally, valid staying high, overrun unchanged.
REQ-026 overrun SHALL clear only on reset.
REQ-027 The bit counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide, restart at 0 after every sample, and never wrap mid-bit.

Reset
REQ-028 While rst is high at a sck edge: state IDLE, counters 0, shift register 0, synchronizer flops 1.
REQ-029 Reset values: data 8'h00, valid 0, frame_err 0, overrun 0, parity_err 0, busy 0.
REQ-030 Reset mid-frame SHALL abandon the frame; a low line after reset release SHALL be treated as a new start edge.

Configuration
REQ-031 Macro UART_RX_PARITY_EN defined: PARITY state present, frame = start + 8 data + even parity + stop, parity_err functional.
REQ-032 Macro UART_RX_PARITY_EN undefined: frame = start + 8 data + stop, PARITY state and logic absent, parity_err tied 0.

Verification
REQ-033 CLKS_PER_BIT=16, frame 0xA5 with valid stop, ready=0 -> valid=1, data=8'hA5 on the cycle after the stop sample; frame_err=0.
REQ-034 rx low pulse of 5 cycles in IDLE -> back to IDLE, valid=0, no flags, busy high for at most 8 cycles.
REQ-035 Frame 0x3C with stop bit 0, then line high -> one frame_err pulse, valid=0, state IDLE after line high.
REQ-036 Frames 0x11 then 0x22, ready held 0 -> data=8'h11, overrun=1; assert ready -> valid clears next cycle.
REQ-037 With UART_RX_PARITY_EN, frame 0x07 with parity bit 0 -> parity_err pulse, valid=0; with parity bit 1 -> data=8'h07, valid=1.
REQ-038 rst asserted at DATA bit 4 -> all outputs at reset values next cycle; the next full frame 0x5A is received correctly.
